// File: rtl/melody_sequencer.sv
// Song-table player feeding the DDS note index: times each note slot, silences its tail, reports status.
// Optional per-slot tempo selection is enabled by defining MELODY_TEMPO_EN.
module melody_sequencer #(
    parameter logic [31:0] BEAT_TICKS = 32'd12_500_000,
    parameter logic [31:0] GAP_TICKS  = 32'd1_250_000,
    parameter int          ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
`ifdef MELODY_TEMPO_EN
    input  logic [1:0]        tempo_sel,
`endif
    output logic [2:0]        note_bin,
    output logic              playing,
    output logic              note_strobe,
    output logic              song_done,
    output logic [ADDR_W-1:0] addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Song table: entries 0..6 climb the scale one beat each, entry 7 is a two-beat tonic.
    function automatic logic [2:0] song_note(input logic [ADDR_W-1:0] a);
        logic [31:0] idx;
        logic [2:0]  n;
        idx = 32'(a);
        case (idx)
            32'd0:   n = 3'd1;
            32'd1:   n = 3'd2;
            32'd2:   n = 3'd3;
            32'd3:   n = 3'd4;
            32'd4:   n = 3'd5;
            32'd5:   n = 3'd6;
            32'd6:   n = 3'd7;
            32'd7:   n = 3'd1;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] song_dur(input logic [ADDR_W-1:0] a);
        logic [31:0] idx;
        logic [3:0]  d;
        idx = 32'(a);
        case (idx)
            32'd0, 32'd1, 32'd2, 32'd3,
            32'd4, 32'd5, 32'd6: d = 4'd1;
            32'd7:               d = 4'd2;
            default:             d = 4'd0;
        endcase
        return d;
    endfunction

    state_t            state_r, state_nx_s;
    logic [31:0]       tick_r, tick_nx_s;
    logic [31:0]       beat_r, beat_nx_s, beat_eff_s;
    logic [ADDR_W-1:0] addr_r, addr_nx_s;
    logic [2:0]        note_r, note_nx_s;
    logic              playing_r, playing_nx_s;
    logic              strobe_r, strobe_nx_s;
    logic              done_r, done_nx_s;

    logic [31:0]       slot_s, gap_end_s;
    logic [ADDR_W:0]   addr_inc_s;
    logic [3:0]        succ_dur_s, entry0_dur_s, tgt_dur_s;
    logic [ADDR_W-1:0] tgt_addr_s;
    logic              slot_start_s;

    // Slot length uses the beat latched when the slot began.
    assign slot_s       = {28'd0, song_dur(addr_r)} * beat_r;
    assign gap_end_s    = slot_s - GAP_TICKS;
    assign addr_inc_s   = {1'b0, addr_r} + {{ADDR_W{1'b0}}, 1'b1};
    assign succ_dur_s   = addr_inc_s[ADDR_W] ? 4'd0 : song_dur(addr_inc_s[ADDR_W-1:0]);
    assign entry0_dur_s = song_dur({ADDR_W{1'b0}});

    // Effective beat for a slot that starts this cycle.
`ifdef MELODY_TEMPO_EN
    always_comb begin
        case (tempo_sel)
            2'd1:    beat_eff_s = BEAT_TICKS >> 1;
            2'd2:    beat_eff_s = BEAT_TICKS << 1;
            default: beat_eff_s = BEAT_TICKS;
        endcase
    end
`else
    assign beat_eff_s = BEAT_TICKS;
`endif

    // Pick the entry the next slot would play; an end marker falls back to entry 0 only when looping.
    always_comb begin
        if ((state_r == ST_GAP) && (succ_dur_s != 4'd0)) begin
            tgt_addr_s = addr_inc_s[ADDR_W-1:0];
            tgt_dur_s  = succ_dur_s;
        end else if ((state_r == ST_GAP) && !loop_en) begin
            tgt_addr_s = {ADDR_W{1'b0}};
            tgt_dur_s  = 4'd0;
        end else begin
            tgt_addr_s = {ADDR_W{1'b0}};
            tgt_dur_s  = entry0_dur_s;
        end
    end

    // State register together with the registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            tick_r    <= 32'd0;
            beat_r    <= BEAT_TICKS;
            addr_r    <= {ADDR_W{1'b0}};
            note_r    <= 3'd0;
            playing_r <= 1'b0;
            strobe_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            tick_r    <= tick_nx_s;
            beat_r    <= beat_nx_s;
            addr_r    <= addr_nx_s;
            note_r    <= note_nx_s;
            playing_r <= playing_nx_s;
            strobe_r  <= strobe_nx_s;
            done_r    <= done_nx_s;
        end
    end

    // Next-state decision; stop overrides everything else.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else if (start) begin
                    state_nx_s = (tgt_dur_s != 4'd0) ? ST_PLAY : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else if (tick_r == gap_end_s) begin
                    state_nx_s = ST_GAP;
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else if (tick_r == slot_s) begin
                    state_nx_s = (tgt_dur_s != 4'd0) ? ST_PLAY : ST_DONE;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the tick counter.
    always_comb begin
        slot_start_s = (state_nx_s == ST_PLAY) && (state_r != ST_PLAY);
        tick_nx_s    = tick_r;
        beat_nx_s    = beat_r;
        addr_nx_s    = addr_r;
        note_nx_s    = note_r;
        strobe_nx_s  = 1'b0;
        done_nx_s    = (state_nx_s == ST_DONE);
        playing_nx_s = (state_nx_s == ST_PLAY) || (state_nx_s == ST_GAP);
        if (slot_start_s) begin
            tick_nx_s   = 32'd1;
            beat_nx_s   = beat_eff_s;
            addr_nx_s   = tgt_addr_s;
            note_nx_s   = song_note(tgt_addr_s);
            strobe_nx_s = 1'b1;
        end else begin
            case (state_nx_s)
                ST_PLAY: tick_nx_s = tick_r + 32'd1;
                ST_GAP: begin
                    tick_nx_s = tick_r + 32'd1;
                    note_nx_s = 3'd0;
                end
                default: begin
                    tick_nx_s = 32'd0;
                    addr_nx_s = {ADDR_W{1'b0}};
                    note_nx_s = 3'd0;
                end
            endcase
        end
    end

    assign note_bin    = note_r;
    assign playing     = playing_r;
    assign note_strobe = strobe_r;
    assign song_done   = done_r;
    assign addr        = addr_r;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer (BEAT_TICKS=8, GAP_TICKS=2); tempo cases need MELODY_TEMPO_EN.
module tb_melody_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [2:0] note_bin;
    logic       playing;
    logic       note_strobe;
    logic       song_done;
    logic [3:0] addr;
`ifdef MELODY_TEMPO_EN
    logic [1:0] tempo_sel = 2'd0;
`endif

    melody_sequencer #(
        .BEAT_TICKS(32'd8),
        .GAP_TICKS (32'd2),
        .ADDR_W    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
`ifdef MELODY_TEMPO_EN
        .tempo_sel  (tempo_sel),
`endif
        .note_bin   (note_bin),
        .playing    (playing),
        .note_strobe(note_strobe),
        .song_done  (song_done),
        .addr       (addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [2:0] note;
        logic [3:0] addr;
        int         cyc;
        int         high;
        int         gap;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_err = 0;
    int  high_cnt = 0;
    int  gap_cnt = 0;
    ev_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input bit d, input int note, input int a, input int c, input int h, input int g);
        ev_t x;
        x.is_done = d;
        x.note    = 3'(note);
        x.addr    = 4'(a);
        x.cyc     = c;
        x.high    = h;
        x.gap     = g;
        q.push_back(x);
    endtask

    // Whole song from a start sampled at the edge after cycle s; first_high < 0 skips the previous-slot check.
    task automatic push_song(input int s, input bit with_done, input int first_high);
        for (int k = 0; k < 8; k++) begin
            push_ev(1'b0, (k < 7) ? k + 1 : 1, k, s + 1 + 8 * k,
                    (k == 0) ? first_high : 6, (k == 0 && first_high < 0) ? -1 : 2);
        end
        if (with_done) push_ev(1'b1, 0, 0, s + 73, 14, 2);
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending events expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: every strobe or done pulse is matched against the head of the expectation queue.
    always @(negedge clk) begin
        if (rst && (note_strobe || song_done)) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_event: got strobe=%0d done=%0d expected none (cycle %0d)",
                         note_strobe, song_done, cyc);
            end else begin
                e = q.pop_front();
                chk("event_kind_done", 32'(song_done), 32'(e.is_done));
                chk("event_kind_strobe", 32'(note_strobe), 32'(!e.is_done));
                chk("event_note", 32'(note_bin), 32'(e.note));
                chk("event_addr", 32'(addr), 32'(e.addr));
                chk("event_playing", 32'(playing), 32'(!e.is_done));
                chk("event_cycle", 32'(cyc), 32'(e.cyc));
                if (e.high >= 0) chk("prev_note_high_len", 32'(high_cnt), 32'(e.high));
                if (e.gap >= 0) chk("prev_gap_len", 32'(gap_cnt), 32'(e.gap));
            end
        end
        if (note_strobe) begin
            high_cnt = 0;
            gap_cnt  = 0;
        end
        if (playing && note_bin != 3'd0) high_cnt++;
        if (playing && note_bin == 3'd0) gap_cnt++;
    end

    int s;

    initial begin
        tick_n(2);
        chk("reset_note_bin", 32'(note_bin), 32'd0);
        chk("reset_playing", 32'(playing), 32'd0);
        chk("reset_strobe", 32'(note_strobe), 32'd0);
        chk("reset_done", 32'(song_done), 32'd0);
        chk("reset_addr", 32'(addr), 32'd0);
        rst = 1'b1;
        tick_n(2);

        // Full song without looping.
        s = cyc;
        start = 1'b1;
        push_song(s, 1'b1, -1);
        tick_n(1);
        start = 1'b0;
        drain(200);
        chk("after_done_playing", 32'(playing), 32'd0);
        chk("after_done_note", 32'(note_bin), 32'd0);

        // Loop once, then drop loop_en during the second pass.
        loop_en = 1'b1;
        tick_n(1);
        s = cyc;
        start = 1'b1;
        push_song(s, 1'b0, -1);
        push_song(s + 72, 1'b1, 14);
        tick_n(1);
        start = 1'b0;
        tick_n(79);
        loop_en = 1'b0;
        drain(200);

        // Stop during tick 3 of note 4, then stop and start together.
        tick_n(1);
        s = cyc;
        start = 1'b1;
        for (int k = 0; k < 4; k++) push_ev(1'b0, k + 1, k, s + 1 + 8 * k, (k == 0) ? -1 : 6, (k == 0) ? -1 : 2);
        tick_n(1);
        start = 1'b0;
        tick_n(26);
        chk("pre_stop_note", 32'(note_bin), 32'd4);
        chk("pre_stop_addr", 32'(addr), 32'd3);
        stop = 1'b1;
        tick_n(1);
        chk("stop_note", 32'(note_bin), 32'd0);
        chk("stop_addr", 32'(addr), 32'd0);
        chk("stop_playing", 32'(playing), 32'd0);
        chk("stop_no_done", 32'(song_done), 32'd0);
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick_n(1);
            chk("stop_start_idle", 32'(playing), 32'd0);
        end
        start = 1'b0;
        stop  = 1'b0;
        chk("stop_queue_empty", 32'(q.size()), 32'd0);
        q.delete();

        // Asynchronous reset during the first gap, then restart.
        tick_n(1);
        s = cyc;
        start = 1'b1;
        push_ev(1'b0, 1, 0, s + 1, -1, -1);
        tick_n(1);
        start = 1'b0;
        tick_n(6);
        chk("gap_note_silent", 32'(note_bin), 32'd0);
        chk("gap_playing", 32'(playing), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_note", 32'(note_bin), 32'd0);
        chk("async_rst_playing", 32'(playing), 32'd0);
        chk("async_rst_strobe", 32'(note_strobe), 32'd0);
        chk("async_rst_done", 32'(song_done), 32'd0);
        chk("async_rst_addr", 32'(addr), 32'd0);
        chk("rst_queue_empty", 32'(q.size()), 32'd0);
        q.delete();
        tick_n(2);
        rst = 1'b1;
        tick_n(2);
        s = cyc;
        start = 1'b1;
        push_ev(1'b0, 1, 0, s + 1, -1, -1);
        push_ev(1'b0, 2, 1, s + 9, 6, 2);
        tick_n(1);
        start = 1'b0;
        drain(40);
        stop = 1'b1;
        tick_n(1);
        stop = 1'b0;
        tick_n(2);

`ifdef MELODY_TEMPO_EN
        // Half beat, then double beat selected mid-slot takes effect on the following slot.
        tempo_sel = 2'd1;
        s = cyc;
        start = 1'b1;
        push_ev(1'b0, 1, 0, s + 1, -1, -1);
        push_ev(1'b0, 2, 1, s + 5, 2, 2);
        push_ev(1'b0, 3, 2, s + 9, 2, 2);
        push_ev(1'b0, 4, 3, s + 25, 14, 2);
        tick_n(1);
        start = 1'b0;
        tick_n(5);
        tempo_sel = 2'd2;
        drain(60);
        stop = 1'b1;
        tick_n(1);
        stop = 1'b0;
        tempo_sel = 2'd0;
        tick_n(2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
